// File: rtl/lsu_mem_access_if.sv
// Data-memory port of lsu_mem_access: one word beat per mem_req/mem_ready handshake.
// For reads, mem_rdata is valid in the same cycle that mem_ready is high.
interface lsu_mem_access_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// RV32I load/store sequencer; splits word-crossing accesses into two beats (LSU_MISALIGN_TRAP_EN traps them instead).
// Latency: done at start+2 aligned, start+3 split, plus one cycle per mem_ready wait.
// Backpressure: each beat holds its outputs until mem_ready; start is ignored while busy.
module lsu_mem_access #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] load_data,
  lsu_mem_access_if.master mem
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic             misalign
`endif
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t state_q, state_d;

  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  // Right-align the addressed bytes of the {hi,lo} pair and clear bytes beyond the access size.
  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [2:0] size,
                                          input logic [1:0] off);
    logic [31:0] shifted;
    logic [31:0] keep;
    shifted = 32'(pair >> {off, 3'b000});
    case (size)
      3'd1:    keep = 32'h0000_00FF;
      3'd2:    keep = 32'h0000_FFFF;
      default: keep = 32'hFFFF_FFFF;
    endcase
    return shifted & keep;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic       dec_ld, dec_st, dec_ok, trap_d, capture;
  logic [2:0] dec_size;
  logic       unused_inst;

  assign opc         = inst[6:0];
  assign f3          = inst[14:12];
  assign unused_inst = ^{inst[31:15], inst[11:7]};

  always_comb begin
    dec_ld = (opc == 7'b0000011);
    dec_st = (opc == 7'b0100011);
    dec_ok = (dec_ld && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
          || (dec_st && (f3 inside {3'b000, 3'b001, 3'b010}));
    case (f3[1:0])
      2'b00:   dec_size = 3'd1;
      2'b01:   dec_size = 3'd2;
      default: dec_size = 3'd4;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [7:0] dec_mask;
  assign dec_mask = lane_mask(dec_size, addr[1:0]);
  assign trap_d   = dec_ok && ((|dec_mask[7:4])
                  || (dec_size == 3'd2 && addr[0])
                  || (dec_size == 3'd4 && addr[1:0] != 2'b00));
`else
  assign trap_d = 1'b0;
`endif

  // Opcodes other than load/store never leave IDLE; a bad funct3 still completes as a no-op.
  assign capture = (state_q == IDLE) && start && (dec_ld || dec_st);

  logic             is_ld_q, is_st_q;
  logic [2:0]       size_q;
  logic [31:0]      addr_q, sdata_q, lo_q, load_data_q;
  logic [7:0]       mask8;
  logic [63:0]      wdata64;
  logic             split;
  logic [31:0]      word_addr;

  assign mask8     = lane_mask(size_q, addr_q[1:0]);
  assign wdata64   = {32'b0, sdata_q} << {addr_q[1:0], 3'b000};
  assign split     = |mask8[7:4];
  assign word_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = (dec_ok && !trap_d) ? ACC1 : DONE;
      ACC1:    if (mem.mem_ready) state_d = split ? ACC2 : DONE;
      ACC2:    if (mem.mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_ld_q     <= 1'b0;
      is_st_q     <= 1'b0;
      size_q      <= 3'd0;
      addr_q      <= 32'd0;
      sdata_q     <= 32'd0;
      lo_q        <= 32'd0;
      load_data_q <= 32'd0;
    end else if (capture) begin
      is_ld_q     <= dec_ld && dec_ok && !trap_d;
      is_st_q     <= dec_st && dec_ok && !trap_d;
      size_q      <= dec_size;
      addr_q      <= addr;
      sdata_q     <= store_data;
      load_data_q <= 32'd0;
    end else if (state_q == ACC1 && mem.mem_ready && is_ld_q) begin
      lo_q <= mem.mem_rdata;
      if (!split) load_data_q <= extract({32'b0, mem.mem_rdata}, size_q, addr_q[1:0]);
    end else if (state_q == ACC2 && mem.mem_ready && is_ld_q) begin
      load_data_q <= extract({mem.mem_rdata, lo_q}, size_q, addr_q[1:0]);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (capture) begin
      misalign_q <= trap_d;
    end
  end
  assign misalign = (state_q == DONE) && misalign_q;
`endif

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = '0;
    case (state_q)
      ACC1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = is_st_q;
        mem.mem_addr  = word_addr;
        mem.mem_be    = mask8[3:0];
        mem.mem_wdata = wdata64[31:0];
      end
      ACC2: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = is_st_q;
        mem.mem_addr  = word_addr + 32'd4;
        mem.mem_be    = mask8[7:4];
        mem.mem_wdata = wdata64[63:32];
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Randomized + directed bench for lsu_mem_access against a byte-level memory model.
// Builds with or without LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_access;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inst = '0, addr = '0, store_data = '0;
  logic        busy, done;
  logic [31:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_mem_access_if #(.WIDTH(32)) mem_if ();

  lsu_mem_access #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .mem(mem_if)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Physical memory (written by DUT beats) and reference memory (written by the model).
  logic [7:0] phys [logic [31:0]];
  logic [7:0] refm [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] phys_word(input logic [31:0] wa);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ai;
      ai = wa + 32'(i);
      w[8*i +: 8] = phys.exists(ai) ? phys[ai] : init_byte(ai);
    end
    return w;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_byte(wa + 32'(i));
    return w;
  endfunction

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  beat_t beat_q[$];
  int    cyc = 0, done_count = 0, acc_count = 0;

  always @(posedge clk) begin
    cyc++;
    if (done) done_count++;
    if (mem_if.mem_req && mem_if.mem_ready) begin
      beat_q.push_back('{mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata});
      acc_count++;
      if (mem_if.mem_we)
        for (int i = 0; i < 4; i++)
          if (mem_if.mem_be[i]) phys[mem_if.mem_addr + 32'(i)] = mem_if.mem_wdata[8*i +: 8];
    end
  end

  // Responder: wait_cfg low-ready cycles per beat; checks the beat stays stable while stalled.
  int          wait_cfg = 0, wcnt = 0, acc_seen = 0, unstable = 0;
  logic [31:0] snap_a, snap_wd;
  logic [3:0]  snap_be;
  logic        snap_we;

  always @(negedge clk) begin
    if (acc_count != acc_seen) begin
      acc_seen = acc_count;
      wcnt = 0;
    end
    mem_if.mem_rdata = $urandom;
    if (!mem_if.mem_req) begin
      mem_if.mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        snap_a = mem_if.mem_addr; snap_be = mem_if.mem_be;
        snap_wd = mem_if.mem_wdata; snap_we = mem_if.mem_we;
      end else if (snap_a !== mem_if.mem_addr || snap_be !== mem_if.mem_be ||
                   snap_wd !== mem_if.mem_wdata || snap_we !== mem_if.mem_we) begin
        unstable++;
      end
      if (wcnt < wait_cfg) begin
        mem_if.mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = phys_word(mem_if.mem_addr);
      end
    end
  end

  function automatic beat_t beat_at(input int i);
    if (i < beat_q.size()) return beat_q[i];
    return '0;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] ti;
    ti = $urandom;
    ti[6:0] = opc;
    ti[14:12] = f3;
    return ti;
  endfunction

  int base;

  task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int waits, input int glitch);
    logic        is_ld, is_st, trap, seen;
    int          n, off, nb_exp, lat_exp, t0;
    logic [31:0] exp_ld, w0;
    is_ld = (opc == OP_LD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    is_st = (opc == OP_ST) && (f3 inside {3'd0, 3'd1, 3'd2});
    n     = 1 << f3[1:0];
    off   = int'(a[1:0]);
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = (is_ld || is_st) && ((off + n > 4) || (n == 2 && off % 2 == 1) || (n == 4 && off != 0));
`endif
    if (!(is_ld || is_st) || trap) begin
      nb_exp = 0;
      lat_exp = 1;
    end else begin
      nb_exp = (off + n > 4) ? 2 : 1;
      lat_exp = 1 + nb_exp * (1 + waits);
    end
    exp_ld = '0;
    if (is_ld && !trap)
      for (int i = 0; i < n; i++) exp_ld[8*i +: 8] = ref_byte(a + 32'(i));

    wait_cfg = waits;
    base = beat_q.size();
    @(negedge clk);
    inst = mk_inst(opc, f3); addr = a; store_data = sd; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (glitch > 0 && k == glitch) begin
        inst = mk_inst(OP_ST, 3'd2); addr = 32'h10; store_data = 32'hFFFF_FFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd1, 32'd0);
    end else begin
      check("latency", 32'(cyc - t0), 32'(lat_exp));
      check("load_data", load_data, exp_ld);
      check("beat_count", 32'(beat_q.size() - base), 32'(nb_exp));
`ifdef LSU_MISALIGN_TRAP_EN
      check("misalign", {31'd0, misalign}, {31'd0, trap});
`endif
      if (is_st && !trap) begin
        for (int i = 0; i < n; i++) refm[a + 32'(i)] = sd[8*i +: 8];
        w0 = a & 32'hFFFF_FFFC;
        check("store_word0", phys_word(w0), ref_word(w0));
        if (nb_exp == 2) check("store_word1", phys_word(w0 + 32'd4), ref_word(w0 + 32'd4));
      end
    end
    @(negedge clk);
    check("done_one_cycle", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int          u0, dc, sel;
    logic [6:0]  ropc;
    logic [2:0]  rf3;
    logic [31:0] ra;

    repeat (2) @(negedge clk);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_ctrl", {26'd0, mem_if.mem_req, mem_if.mem_we, mem_if.mem_be}, 32'd0);
    check("rst_mem_addr", mem_if.mem_addr, 32'd0);
    check("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    rst_n = 1'b1;

    run(OP_ST, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0);
    run(OP_LD, 3'd2, 32'h100, 32'h0, 0, 0);
    check("lw_addr", beat_at(base).a, 32'h100);
    check("lw_be", {28'd0, beat_at(base).be}, 32'hF);
    check("lw_data", load_data, 32'hDEAD_BEEF);

    run(OP_ST, 3'd2, 32'h100, 32'h80AA_BBCC, 0, 0);
    run(OP_LD, 3'd0, 32'h103, 32'h0, 0, 0);
    check("lb_be", {28'd0, beat_at(base).be}, 32'h8);
    check("lb_data", load_data, 32'h0000_0080);

    run(OP_ST, 3'd1, 32'h102, 32'h1234_ABCD, 0, 0);
    check("sh_we_be", {27'd0, beat_at(base).we, beat_at(base).be}, 32'h1C);
    check("sh_wdata", beat_at(base).wd, 32'hABCD_0000);

    run(OP_ST, 3'd2, 32'h201, 32'h1122_3344, 0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    check("sw_b1_addr", beat_at(base).a, 32'h200);
    check("sw_b1_be", {28'd0, beat_at(base).be}, 32'hE);
    check("sw_b1_wdata", beat_at(base).wd, 32'h2233_4400);
    check("sw_b2_addr", beat_at(base + 1).a, 32'h204);
    check("sw_b2_be", {28'd0, beat_at(base + 1).be}, 32'h1);
    check("sw_b2_wdata", beat_at(base + 1).wd, 32'h0000_0011);
`endif

    u0 = unstable;
    run(OP_LD, 3'd2, 32'h10, 32'h0, 3, 1);
    check("stall_stable", 32'(unstable - u0), 32'd0);
    check("busy_start_ignored", phys_word(32'h10), ref_word(32'h10));

    run(OP_LD, 3'd1, 32'hFFFF_FFFF, 32'h0, 1, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    check("wrap_b1_addr", beat_at(base).a, 32'hFFFF_FFFC);
    check("wrap_b2_addr", beat_at(base + 1).a, 32'h0);
`endif

    run(OP_LD, 3'd3, 32'h40, 32'h0, 0, 0);

    // Abort an access while its memory beat is stalled.
    wait_cfg = 5;
    base = beat_q.size();
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    inst = mk_inst(OP_LD, 3'd2); addr = 32'h1FC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
`else
    inst = mk_inst(OP_LD, 3'd2); addr = 32'h1FE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (beat_q.size() > base) break;
      @(negedge clk);
    end
    check("rst_setup_beat1", 32'(beat_q.size() - base), 32'd1);
    @(negedge clk);
`endif
    check("pre_rst_req", {31'd0, mem_if.mem_req}, 32'd1);
    dc = done_count;
    rst_n = 1'b0;
    #1;
    check("abort_req_busy", {30'd0, mem_if.mem_req, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    rst_n = 1'b1;
    run(OP_LD, 3'd2, 32'h100, 32'h0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin ropc = OP_LD; rf3 = 3'd0; end
        1: begin ropc = OP_LD; rf3 = 3'd1; end
        2: begin ropc = OP_LD; rf3 = 3'd2; end
        3: begin ropc = OP_LD; rf3 = 3'd4; end
        4: begin ropc = OP_LD; rf3 = 3'd5; end
        5: begin ropc = OP_ST; rf3 = 3'd0; end
        6: begin ropc = OP_ST; rf3 = 3'd1; end
        default: begin ropc = OP_ST; rf3 = 3'd2; end
      endcase
      ra = 32'h300 + 32'($urandom_range(0, 31));
      run(ropc, rf3, ra, $urandom, $urandom_range(0, 2), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store access sequencer between the execute stage and the data memory port; feeds `data_extract` directly.
- For RV32I loads and stores, computes word address, byte enables and lane-shifted store data.
- Runs a request/ready handshake with data memory.
- Returns the load word right-aligned (requested byte in [7:0]) so `data_extract` only sign/zero-extends.
- Splits misaligned accesses that cross a word boundary into two word-aligned beats.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: issue access described by inst/addr/store_data.
- inst  input  WIDTH  current instruction; uses [6:0] opcode and [14:12] funct3.
- addr  input  WIDTH  effective byte address (rs1+imm) from ALU.
- store_data  input  WIDTH  rs2 value, right-aligned.
- busy  output  1  high while an access is in flight (state != IDLE).
- done  output  1  one-cycle pulse: access complete.
- load_data  output  WIDTH  right-aligned raw load word, to `data_extract` data input; valid while done=1, held until next start.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write beat.
- mem_addr  output  WIDTH  word-aligned address, [1:0] always 00.
- mem_be  output  4  byte enables for the beat.
- mem_wdata  output  WIDTH  lane-positioned write data.
- mem_ready  input  1  memory accepts beat this cycle; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  input  WIDTH  read data word.

Behaviour:
- Reset, asynchronous: state=IDLE; every output 0; captured registers 0. Reset mid-access drops mem_req immediately; no done is issued for the aborted access.
- Decode:
  - Load: opcode 0000011; size by funct3 000/100=1B, 001/101=2B, 010=4B.
  - Store: opcode 0100011; size by funct3 000=1B, 001=2B, 010=4B.
  - Any other opcode/funct3 combination is a no-op access.
- Capture at IDLE&&start: inst fields, addr, store_data.
- Masks, with off=addr[1:0] and n=size:
  - mask8 = ((1<<n)-1) << off, 8 bits.
  - wdata64 = {32'b0, store_data} << (8*off).
  - split = |mask8[7:4].
- States:
  - IDLE:
    - start with load/store → ACC1.
    - start with no-op → DONE, no mem_req, load_data=0.
    - start with no decode at all → stays IDLE.
  - ACC1:
    - Drives mem_req=1, mem_we=store, mem_addr={addr[31:2],2'b00}, mem_be=mask8[3:0], mem_wdata=wdata64[31:0].
    - Outputs are stable until mem_ready.
    - On mem_ready: load captures mem_rdata into lo; next state is ACC2 if split, else DONE.
  - ACC2:
    - Drives mem_req=1, mem_addr={addr[31:2],2'b00}+4 (wraps mod 2^32 at 0xFFFFFFFC), mem_be=mask8[7:4], mem_wdata=wdata64[63:32].
    - On mem_ready: load captures hi; next state is DONE.
  - DONE:
    - done=1 for one cycle, mem_req=0; next state is IDLE.
    - load_data = ({hi,lo} >> 8*off)[31:0] with bytes beyond n forced to 0.
    - For stores, load_data=0.
- Cycle counts: aligned access with mem_ready already high completes with done at cycle start+2; a split access with zero wait completes at start+3. Each wait cycle adds 1.
- start while busy=1 is ignored: no capture, no effect.
- mem_req deasserts in the same cycle mem_ready completes the final beat; there are no back-to-back beats of different accesses.

Optional Feature:
- LSU_MISALIGN_TRAP_EN.
- Defined:
  - Any access with split=1, or a halfword at odd offset, or a word at off!=0, goes IDLE→DONE with no mem_req.
  - misalign output (1 bit, added port) pulses with done.
  - load_data=0.
  - Stores do not write.
- Undefined: the misalign port is absent and misaligned accesses are split as above.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, mem_ready tied 1 → mem_be=1111, mem_addr=0x100, done at start+2, load_data=0xDEADBEEF.
- LB addr=0x103, rdata=0x80AABBCC → be=1000, load_data=0x00000080; `data_extract` downstream yields 0xFFFFFF80.
- SH addr=0x102, store_data=0x1234ABCD → single beat, be=1100, wdata=0xABCD0000, mem_we=1.
- SW addr=0x201, store_data=0x11223344, macro off:
  - Beat1: addr 0x200, be=1110, wdata=0x22334400.
  - Beat2: addr 0x204, be=0001, wdata=0x00000011.
  - done at start+3; with macro on: no mem_req, misalign=1.
- LW addr=0x10, mem_ready low 3 cycles → mem_req/addr/be held stable; done 3 cycles later than zero-wait; a start pulsed while busy is ignored.
- rst_n low during ACC2 wait → mem_req=0 and busy=0 immediately; no done; next LW after release completes normally.
